// File: rtl/serdes_align_ctrl.sv
// Per-lane word-alignment controller for a 1:10 DDR deserializer: holds it in reset, then bitslips until Q matches PATTERN.
// Optional `define ALIGN_RELOCK_EN adds a miss counter in S_LOCKED that re-enters the slip search after MISS_LIMIT misses.
module serdes_align_ctrl #(
    parameter logic [9:0] PATTERN    = 10'b1111100000,
    parameter int         RST_CYC    = 8,
    parameter int         SETTLE_CYC = 4,
    parameter int         VERIFY_CNT = 16,
    parameter int         MISS_LIMIT = 4
) (
    input  logic       clkdiv_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [9:0] q_i,
    output logic       serdes_rst_o,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [3:0] slip_cnt_o
);

    localparam int CNT_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int MW      = $clog2(VERIFY_CNT + 1);
    localparam logic [3:0] SLIP_MAX = 4'd10;

    generate
        if (SETTLE_CYC < 1 || VERIFY_CNT < 1 || MISS_LIMIT < 1 || RST_CYC < 1) begin : g_param_err
            $error("serdes_align_ctrl: RST_CYC, SETTLE_CYC, VERIFY_CNT and MISS_LIMIT must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_RST,
        S_SETTLE,
        S_VERIFY,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]  match_q, match_d;
    logic [3:0]     slip_q, slip_d;
    logic           serdes_rst_q, bitslip_q, locked_q, fail_q;
    logic           word_match;

`ifdef ALIGN_RELOCK_EN
    localparam int XW = $clog2(MISS_LIMIT + 1);
    logic [XW-1:0]  miss_q, miss_d;
`endif

    assign word_match = (q_i == PATTERN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        slip_d  = slip_q;
`ifdef ALIGN_RELOCK_EN
        miss_d  = miss_q;
`endif
        case (state_q)
            S_RST: begin
                if (cnt_q == CW'(RST_CYC)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    slip_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    state_d = S_VERIFY;
                    cnt_d   = '0;
                    match_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VERIFY: begin
                if (word_match) begin
                    if (match_q == MW'(VERIFY_CNT - 1)) begin
                        state_d = S_LOCKED;
`ifdef ALIGN_RELOCK_EN
                        miss_d  = '0;
`endif
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else if (slip_q >= SLIP_MAX) begin
                    state_d = S_FAIL;
                end else begin
                    // The slip counter advances together with the BITSLIP pulse.
                    state_d = S_SLIP;
                    slip_d  = slip_q + 4'd1;
                end
            end
            S_SLIP: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_LOCKED: begin
`ifdef ALIGN_RELOCK_EN
                if (word_match) begin
                    miss_d = '0;
                end else if (miss_q == XW'(MISS_LIMIT - 1)) begin
                    // Fresh search: the count restarts, and this slip is the first of it.
                    state_d = S_SLIP;
                    slip_d  = 4'd1;
                    miss_d  = '0;
                end else begin
                    miss_d = miss_q + 1'b1;
                end
`endif
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase

        if (start_i) begin
            state_d = S_RST;
            cnt_d   = '0;
            match_d = '0;
            slip_d  = '0;
`ifdef ALIGN_RELOCK_EN
            miss_d  = '0;
`endif
        end
    end

    // Outputs are decoded from the next state so they are registered and line up with the state register.
    always_ff @(posedge clkdiv_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_RST;
            cnt_q        <= '0;
            match_q      <= '0;
            slip_q       <= '0;
            serdes_rst_q <= 1'b1;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            slip_q       <= slip_d;
            serdes_rst_q <= (state_d == S_RST);
            bitslip_q    <= (state_d == S_SLIP);
            locked_q     <= (state_d == S_LOCKED);
            fail_q       <= (state_d == S_FAIL);
        end
    end

`ifdef ALIGN_RELOCK_EN
    always_ff @(posedge clkdiv_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end
`endif

    assign serdes_rst_o = serdes_rst_q;
    assign bitslip_o    = bitslip_q;
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;
    assign slip_cnt_o   = slip_q;

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Scoreboard bench for serdes_align_ctrl: a bitslip deserializer model feeds Q; expected output events are queued per test.
module tb_serdes_align_ctrl;

    localparam logic [9:0] PAT = 10'b1111100000;

    typedef enum int {
        EV_SRST_RISE, EV_SRST_FALL, EV_FAIL_FALL, EV_LOCK_FALL,
        EV_SLIP, EV_LOCK_RISE, EV_FAIL_RISE
    } ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
        int  sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] q;
    logic       serdes_rst, bitslip, locked, fail;
    logic [3:0] slip_cnt;

    int         cyc = -1;
    int         init_off = 0;
    int         off = 0;
    bit         never_match = 1'b0;
    logic [255:0] corrupt = '0;
    logic [19:0]  dbl;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    logic p_srst = 1'b1, p_lock = 1'b0, p_fail = 1'b0;

    always #5 clk = ~clk;

    serdes_align_ctrl dut (
        .clkdiv_i     (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .q_i          (q),
        .serdes_rst_o (serdes_rst),
        .bitslip_o    (bitslip),
        .locked_o     (locked),
        .fail_o       (fail),
        .slip_cnt_o   (slip_cnt)
    );

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : -1;

    // Deserializer model: SERDES_RST restores the lane's initial offset; each BITSLIP advances it by one bit.
    always @(posedge clk) begin
        if (serdes_rst) off <= init_off;
        else if (bitslip) off <= (off == 9) ? 0 : off + 1;
    end

    always_comb begin
        dbl = {PAT, PAT} >> (10 - off);
        q   = dbl[9:0];
        if (never_match) q = 10'd0;
        if (cyc >= 0 && cyc < 256 && corrupt[cyc[7:0]]) q = ~q;
    end

    task automatic check_eq(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic expect_ev(input ev_e k, input int c, input int sc);
        exp_t e;
        e.kind = k; e.cyc = c; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic got(input ev_e k);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_event: got %s at cycle %0d slip_cnt %0d, expected none", k.name(), cyc, slip_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.sc != int'(slip_cnt)) begin
                fails++;
                $display("[TB] FAIL event: got %s at cycle %0d slip_cnt %0d, expected %s at cycle %0d slip_cnt %0d",
                         k.name(), cyc, slip_cnt, e.kind.name(), e.cyc, e.sc);
            end else begin
                $display("[TB] ok event %s at cycle %0d slip_cnt %0d", k.name(), cyc, slip_cnt);
            end
        end
    endtask

    // Monitor: turns output edges into events and retires them against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            p_srst <= 1'b1;
            p_lock <= 1'b0;
            p_fail <= 1'b0;
        end else begin
            if (serdes_rst && !p_srst) got(EV_SRST_RISE);
            if (!serdes_rst && p_srst) got(EV_SRST_FALL);
            if (!fail && p_fail)       got(EV_FAIL_FALL);
            if (!locked && p_lock)     got(EV_LOCK_FALL);
            if (bitslip)               got(EV_SLIP);
            if (locked && !p_lock)     got(EV_LOCK_RISE);
            if (fail && !p_fail)       got(EV_FAIL_RISE);
            p_srst <= serdes_rst;
            p_lock <= locked;
            p_fail <= fail;
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("[TB] FAIL wait_cyc: cycle %0d never reached, at %0d", n, cyc);
                fails++;
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic do_reset(input int o, input bit nm);
        rst_n = 1'b0;
        init_off = o;
        never_match = nm;
        corrupt = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic end_test(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_pending: %0d expected events outstanding, required 0", name, exp_q.size());
        end else begin
            $display("[TB] ok %s complete", name);
        end
        exp_q.delete();
    endtask

    initial begin
        // Power-up reset state
        repeat (3) @(negedge clk);
        check_eq("rst_serdes_rst", serdes_rst, 1);
        check_eq("rst_bitslip", bitslip, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_fail", fail, 0);
        check_eq("rst_slip_cnt", slip_cnt, 0);

        // Aligned from the start: SERDES_RST cycles 0-7, lock at 28, no slips
        do_reset(0, 1'b0);
        expect_ev(EV_SRST_FALL, 8, 0);
        expect_ev(EV_LOCK_RISE, 28, 0);
        wait_cyc(40);
        check_eq("aligned_slip_cnt", slip_cnt, 0);
        end_test("aligned");

        // Three slips needed: pulses 6 cycles apart, lock 18 cycles later
        do_reset(7, 1'b0);
        expect_ev(EV_SRST_FALL, 8, 0);
        for (int k = 0; k < 3; k++) expect_ev(EV_SLIP, 13 + 6 * k, k + 1);
        expect_ev(EV_LOCK_RISE, 46, 3);
        wait_cyc(60);
        end_test("three_slips");

        // Never matches: ten slips, FAIL at 73, then START
        do_reset(0, 1'b1);
        expect_ev(EV_SRST_FALL, 8, 0);
        for (int k = 0; k < 10; k++) expect_ev(EV_SLIP, 13 + 6 * k, k + 1);
        expect_ev(EV_FAIL_RISE, 73, 10);
        wait_cyc(100);
        check_eq("fail_locked", locked, 0);
        check_eq("fail_slip_cnt", slip_cnt, 10);
        expect_ev(EV_SRST_RISE, 101, 0);
        expect_ev(EV_FAIL_FALL, 101, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(105);
        end_test("never_match");

        // Corrupt word at verify count 10: slip breaks alignment, full wrap of 10 slips relocks at 98
        do_reset(0, 1'b0);
        corrupt[22] = 1'b1;
        expect_ev(EV_SRST_FALL, 8, 0);
        for (int k = 0; k < 10; k++) expect_ev(EV_SLIP, 23 + 6 * k, k + 1);
        expect_ev(EV_LOCK_RISE, 98, 10);
        wait_cyc(105);
        end_test("corrupt_word");

        // Lock-loss behaviour
        do_reset(0, 1'b0);
        expect_ev(EV_SRST_FALL, 8, 0);
        expect_ev(EV_LOCK_RISE, 28, 0);
`ifdef ALIGN_RELOCK_EN
        corrupt[30] = 1'b1; corrupt[31] = 1'b1; corrupt[32] = 1'b1;
        for (int c = 35; c <= 38; c++) corrupt[c] = 1'b1;
        expect_ev(EV_LOCK_FALL, 39, 1);
        expect_ev(EV_SLIP, 39, 1);
        wait_cyc(41);
`else
        for (int c = 30; c <= 34; c++) corrupt[c] = 1'b1;
        wait_cyc(45);
        check_eq("sticky_locked", locked, 1);
`endif
        end_test("lock_loss");

        // RST_N asserted while BITSLIP is high
        do_reset(7, 1'b0);
        expect_ev(EV_SRST_FALL, 8, 0);
        expect_ev(EV_SLIP, 13, 1);
        wait_cyc(13);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_bitslip", bitslip, 0);
        check_eq("async_serdes_rst", serdes_rst, 1);
        check_eq("async_locked", locked, 0);
        check_eq("async_fail", fail, 0);
        check_eq("async_slip_cnt", slip_cnt, 0);
        end_test("async_rst");
        do_reset(7, 1'b0);
        expect_ev(EV_SRST_FALL, 8, 0);
        for (int k = 0; k < 3; k++) expect_ev(EV_SLIP, 13 + 6 * k, k + 1);
        expect_ev(EV_LOCK_RISE, 46, 3);
        wait_cyc(55);
        end_test("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
